// File: rtl/ic_diag_pkg.sv
// ============================================================================
// Module : ic_diag_pkg
// Brief  : Shared widths, packet type and state encoding for the I-cache
//          diagnostic responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ic_diag_pkg;

    localparam int ADDR_W  = 10;
    localparam int WAY_W   = 2;
    localparam int DATA_W  = 71;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic              tag_sel;
        logic [ADDR_W-1:0] addr;
        logic [WAY_W-1:0]  way;
        logic [DATA_W-1:0] wrdata;
    } ic_diag_pkt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ic_diag_timeout_ctr.sv
// ============================================================================
// Module : ic_diag_timeout_ctr
// Brief  : Saturating read-wait counter; flags the cycle whose count reaches
//          TIMEOUT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ic_diag_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next;

    always_comb begin
        w_next = r_cnt;
        if (i_en && (r_cnt != C_MAX)) begin
            w_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    // Expiry looks at the count being committed this edge so the FSM can
    // leave on exactly the TIMEOUT-th waiting cycle.
    assign o_expired = i_en && (w_next == C_MAX);

endmodule

`default_nettype wire

// File: rtl/ic_diag_responder.sv
// ============================================================================
// Module : ic_diag_responder
// Brief  : IFU endpoint of the I-cache diagnostic path; one array access per
//          packet, read data or write-done/error response back to dec_tlu.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ic_diag_responder
    import ic_diag_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              diag_valid,
    output logic              diag_ready,
    input  logic              diag_rd,
    input  logic              diag_wr,
    input  logic              diag_tag_sel,
    input  logic [ADDR_W-1:0] diag_addr,
    input  logic [WAY_W-1:0]  diag_way,
    input  logic [DATA_W-1:0] diag_wrdata,
    output logic              arr_req,
    input  logic              arr_gnt,
    output logic              arr_we,
    output logic              arr_tag_sel,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [WAY_W-1:0]  arr_way,
    output logic [DATA_W-1:0] arr_wdata,
    input  logic              arr_rvalid,
    input  logic [DATA_W-1:0] arr_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    state_e            r_state;
    state_e            w_state_nxt;
    ic_diag_pkt_t      r_pkt;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic w_legal;
    logic w_accept;
    logic w_grant;
    logic w_wait;
    logic w_expired;

    assign w_legal  = diag_rd ^ diag_wr;
    assign w_accept = (r_state == IDLE) && diag_valid;
    assign w_grant  = (r_state == REQ) && arr_gnt;
    assign w_wait   = (r_state == WAIT_RD);

    ic_diag_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_grant),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (diag_valid) begin
                    w_state_nxt = w_legal ? REQ : RESP;
                end
            end
            REQ: begin
                if (arr_gnt) begin
                    w_state_nxt = r_pkt.rd ? WAIT_RD : RESP;
                end
            end
            WAIT_RD: begin
                if (arr_rvalid || w_expired) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response fields are zero outside RESP, so a write completes with
    // rsp_data already cleared and nothing extra to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_legal) begin
                    r_pkt <= '{rd: diag_rd, wr: diag_wr, tag_sel: diag_tag_sel,
                               addr: diag_addr, way: diag_way, wrdata: diag_wrdata};
                end else begin
                    r_rsp_err <= 1'b1;
                end
            end
            if (w_wait) begin
                if (arr_rvalid) begin
                    r_rsp_data <= arr_rdata;
                    r_rsp_err  <= 1'b0;
                end else if (w_expired) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                end
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign diag_ready  = (r_state == IDLE);
    assign arr_req     = (r_state == REQ);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign arr_we      = r_pkt.wr;
    assign arr_tag_sel = r_pkt.tag_sel;
    assign arr_addr    = r_pkt.addr;
    assign arr_way     = r_pkt.way;
    assign arr_wdata   = r_pkt.wrdata;

endmodule

`default_nettype wire

// File: tb/tb_ic_diag_responder.sv
// ============================================================================
// Module : tb_ic_diag_responder
// Brief  : Self-checking bench for ic_diag_responder against a latency/result
//          model derived from the transaction rules.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ic_diag_responder;
    import ic_diag_pkg::*;

    logic              clk;
    logic              rst;
    logic              diag_valid;
    logic              diag_ready;
    logic              diag_rd;
    logic              diag_wr;
    logic              diag_tag_sel;
    logic [ADDR_W-1:0] diag_addr;
    logic [WAY_W-1:0]  diag_way;
    logic [DATA_W-1:0] diag_wrdata;
    logic              arr_req;
    logic              arr_gnt;
    logic              arr_we;
    logic              arr_tag_sel;
    logic [ADDR_W-1:0] arr_addr;
    logic [WAY_W-1:0]  arr_way;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_rvalid;
    logic [DATA_W-1:0] arr_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    int total = 0;
    int bad   = 0;

    ic_diag_responder dut (
        .clk          (clk),
        .rst          (rst),
        .diag_valid   (diag_valid),
        .diag_ready   (diag_ready),
        .diag_rd      (diag_rd),
        .diag_wr      (diag_wr),
        .diag_tag_sel (diag_tag_sel),
        .diag_addr    (diag_addr),
        .diag_way     (diag_way),
        .diag_wrdata  (diag_wrdata),
        .arr_req      (arr_req),
        .arr_gnt      (arr_gnt),
        .arr_we       (arr_we),
        .arr_tag_sel  (arr_tag_sel),
        .arr_addr     (arr_addr),
        .arr_way      (arr_way),
        .arr_wdata    (arr_wdata),
        .arr_rvalid   (arr_rvalid),
        .arr_rdata    (arr_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand71();
        logic [95:0] v;
        v = {$urandom, $urandom, $urandom};
        return v[DATA_W-1:0];
    endfunction

    // Model: rdelay is the waiting cycle (1-based) on which rvalid arrives,
    // 0 meaning never. The read waits at most TIMEOUT cycles.
    function automatic bit m_legal(input bit rd, input bit wr);
        return rd != wr;
    endfunction

    function automatic bit m_data_ok(input bit rd, input bit wr, input int rdelay);
        return m_legal(rd, wr) && rd && (rdelay >= 1) && (rdelay <= TIMEOUT);
    endfunction

    function automatic bit m_err(input bit rd, input bit wr, input int rdelay);
        if (!m_legal(rd, wr)) return 1'b1;
        if (wr) return 1'b0;
        return !m_data_ok(rd, wr, rdelay);
    endfunction

    function automatic int m_lat(input bit rd, input bit wr, input int g, input int rdelay);
        if (!m_legal(rd, wr)) return 1;
        if (wr) return g + 2;
        return g + 2 + (m_data_ok(rd, wr, rdelay) ? rdelay : TIMEOUT);
    endfunction

    // Drives one packet and plays the array and dec_tlu sides, reporting
    // what was observed. All sampling and driving happens on negedges.
    task automatic run_txn(
        input  bit              rd,
        input  bit              wr,
        input  bit              tag,
        input  logic [ADDR_W-1:0] addr,
        input  logic [WAY_W-1:0]  way,
        input  logic [DATA_W-1:0] wdata,
        input  int              g,
        input  int              rdelay,
        input  int              rr,
        input  logic [DATA_W-1:0] rdata,
        output int              lat,
        output logic [DATA_W-1:0] odata,
        output logic            oerr,
        output int              reqc,
        output bit              arr_ok,
        output bit              stable_ok,
        output logic            ready_after
    );
        int  cyc;
        int  wcnt;
        int  rcyc;
        bit  granted;
        bit  seen;
        bit  hs;
        lat = 0; odata = '0; oerr = 1'b0; reqc = 0; arr_ok = 1'b1; stable_ok = 1'b1;
        wcnt = 0; rcyc = 0; granted = 0; seen = 0; hs = 0;
        diag_valid = 1'b1; diag_rd = rd; diag_wr = wr; diag_tag_sel = tag;
        diag_addr = addr; diag_way = way; diag_wrdata = wdata;
        @(negedge clk);
        diag_valid = 1'b0;
        diag_wrdata = rand71();
        diag_addr = ADDR_W'($urandom);
        cyc = 1;
        while (!hs && cyc < 300) begin
            arr_gnt = 1'b0; arr_rvalid = 1'b0; rsp_ready = 1'b0;
            arr_rdata = rand71();
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1; lat = cyc; odata = rsp_data; oerr = rsp_err;
                end
                if (rsp_data !== odata || rsp_err !== oerr || diag_ready !== 1'b0 || arr_req !== 1'b0)
                    stable_ok = 1'b0;
                if (rcyc == rr) begin
                    rsp_ready = 1'b1; hs = 1;
                end
                rcyc++;
            end else if (arr_req) begin
                reqc++;
                if (arr_we !== wr || arr_tag_sel !== tag || arr_addr !== addr ||
                    arr_way !== way || arr_wdata !== wdata)
                    arr_ok = 1'b0;
                if (reqc > g) begin
                    arr_gnt = 1'b1; granted = 1;
                end
            end else if (granted && rd) begin
                wcnt++;
                if (wcnt == rdelay) begin
                    arr_rvalid = 1'b1; arr_rdata = rdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        arr_gnt = 1'b0; arr_rvalid = 1'b0; rsp_ready = 1'b0;
        ready_after = diag_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (diag_ready !== 1'b1 || arr_req !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_data !== '0 || arr_we !== 1'b0 || arr_tag_sel !== 1'b0 || arr_addr !== '0 ||
            arr_way !== '0 || arr_wdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b req=%b rvalid=%b err=%b data=%h expected ready=1 others 0",
                     diag_ready, arr_req, rsp_valid, rsp_err, rsp_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_data_read();
        int lat; logic [DATA_W-1:0] d; logic e; int rq; bit ao; bit so; logic ra;
        logic [DATA_W-1:0] rdv;
        rdv = 71'h1_2345_6789_ABCD_EF01;
        run_txn(1, 0, 0, 10'h155, 2'd2, rand71(), 0, 3, 0, rdv, lat, d, e, rq, ao, so, ra);
        total++;
        if (d !== rdv || e !== 1'b0) begin
            bad++;
            $display("FAIL read_data: got data=%h err=%b expected data=%h err=0", d, e, rdv);
        end
        total++;
        if (lat !== m_lat(1, 0, 0, 3) || rq !== 1 || ao !== 1'b1) begin
            bad++;
            $display("FAIL read_timing: got lat=%0d req_cycles=%0d arr_ok=%b expected lat=%0d req_cycles=1 arr_ok=1",
                     lat, rq, ao, m_lat(1, 0, 0, 3));
        end
    endtask

    task automatic test_tag_write();
        int lat; logic [DATA_W-1:0] d; logic e; int rq; bit ao; bit so; logic ra;
        run_txn(0, 1, 1, 10'h2A3, 2'd1, rand71(), 5, 0, 0, '0, lat, d, e, rq, ao, so, ra);
        total++;
        if (rq !== 6 || ao !== 1'b1) begin
            bad++;
            $display("FAIL write_req_hold: got req_cycles=%0d arr_ok=%b expected 6 and 1", rq, ao);
        end
        total++;
        if (d !== '0 || e !== 1'b0 || lat !== m_lat(0, 1, 5, 0)) begin
            bad++;
            $display("FAIL write_resp: got data=%h err=%b lat=%0d expected data=0 err=0 lat=%0d",
                     d, e, lat, m_lat(0, 1, 5, 0));
        end
    endtask

    task automatic test_illegal();
        int lat; logic [DATA_W-1:0] d; logic e; int rq; bit ao; bit so; logic ra;
        for (int k = 0; k < 2; k++) begin
            bit b;
            b = (k == 0);
            run_txn(b, b, 0, 10'h3FF, 2'd3, rand71(), 0, 1, 0, rand71(), lat, d, e, rq, ao, so, ra);
            total++;
            if (rq !== 0 || e !== 1'b1 || d !== '0 || lat !== 1) begin
                bad++;
                $display("FAIL illegal_pkt rd=wr=%b: got req_cycles=%0d err=%b data=%h lat=%0d expected 0 1 0 1",
                         b, rq, e, d, lat);
            end
        end
    endtask

    task automatic test_timeout();
        int lat; logic [DATA_W-1:0] d; logic e; int rq; bit ao; bit so; logic ra;
        logic [DATA_W-1:0] rdv;
        int delays [3] = '{0, 15, 16};
        int gs     [3] = '{0, 2, 1};
        for (int k = 0; k < 3; k++) begin
            rdv = rand71();
            run_txn(1, 0, 1, 10'h0F0, 2'd0, rand71(), gs[k], delays[k], 0, rdv, lat, d, e, rq, ao, so, ra);
            total++;
            if (e !== m_err(1, 0, delays[k]) ||
                d !== (m_data_ok(1, 0, delays[k]) ? rdv : '0) ||
                lat !== m_lat(1, 0, gs[k], delays[k])) begin
                bad++;
                $display("FAIL timeout rdelay=%0d: got err=%b data=%h lat=%0d expected err=%b lat=%0d",
                         delays[k], e, d, lat, m_err(1, 0, delays[k]), m_lat(1, 0, gs[k], delays[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [DATA_W-1:0] d; logic e; int rq; bit ao; bit so; logic ra;
        logic [DATA_W-1:0] rdv;
        rdv = rand71();
        run_txn(1, 0, 0, 10'h011, 2'd3, rand71(), 1, 2, 4, rdv, lat, d, e, rq, ao, so, ra);
        total++;
        if (so !== 1'b1 || d !== rdv || e !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_stable: got stable=%b data=%h err=%b expected stable=1 data=%h err=0",
                     so, d, e, rdv);
        end
        total++;
        if (ra !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_handshake: got %b expected 1", ra);
        end
        rdv = rand71();
        run_txn(1, 0, 1, 10'h222, 2'd1, rand71(), 0, 1, 0, rdv, lat, d, e, rq, ao, so, ra);
        total++;
        if (d !== rdv || e !== 1'b0 || lat !== m_lat(1, 0, 0, 1) || ao !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back: got data=%h err=%b lat=%0d expected data=%h err=0 lat=%0d",
                     d, e, lat, rdv, m_lat(1, 0, 0, 1));
        end
    endtask

    task automatic test_rst_midflight();
        int strays;
        diag_valid = 1'b1; diag_rd = 1'b1; diag_wr = 1'b0; diag_tag_sel = 1'b1;
        diag_addr = 10'h1C3; diag_way = 2'd2; diag_wrdata = rand71();
        @(negedge clk);
        diag_valid = 1'b0;
        arr_gnt = 1'b1;
        @(negedge clk);
        arr_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (diag_ready !== 1'b1 || arr_req !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_data !== '0 || arr_we !== 1'b0 || arr_tag_sel !== 1'b0 || arr_addr !== '0 ||
            arr_way !== '0 || arr_wdata !== '0) begin
            bad++;
            $display("FAIL rst_midflight: ready=%b req=%b rvalid=%b err=%b addr=%h expected reset values",
                     diag_ready, arr_req, rsp_valid, rsp_err, arr_addr);
        end
        arr_rvalid = 1'b1; arr_rdata = rand71();
        @(negedge clk);
        arr_rvalid = 1'b0;
        strays = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid !== 1'b0 || diag_ready !== 1'b1) strays++;
            @(negedge clk);
        end
        total++;
        if (strays != 0) begin
            bad++;
            $display("FAIL stray_rvalid: got %0d cycles with a response expected 0", strays);
        end
    endtask

    task automatic test_random();
        int lat; logic [DATA_W-1:0] d; logic e; int rq; bit ao; bit so; logic ra;
        logic [DATA_W-1:0] rdv;
        bit rd, wr; int g, rdl, rr;
        for (int n = 0; n < 30; n++) begin
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 5) == 0) ? rd : !rd;
            g   = $urandom_range(0, 4);
            rdl = $urandom_range(0, 17);
            rr  = $urandom_range(0, 3);
            rdv = rand71();
            run_txn(rd, wr, 1'($urandom_range(0, 1)), ADDR_W'($urandom), WAY_W'($urandom), rand71(),
                    g, rdl, rr, rdv, lat, d, e, rq, ao, so, ra);
            total++;
            if (e !== m_err(rd, wr, rdl) ||
                d !== (m_data_ok(rd, wr, rdl) ? rdv : '0) ||
                lat !== m_lat(rd, wr, g, rdl) ||
                rq !== (m_legal(rd, wr) ? g + 1 : 0) ||
                ao !== 1'b1 || so !== 1'b1 || ra !== 1'b1) begin
                bad++;
                $display("FAIL random[%0d] rd=%b wr=%b g=%0d rdl=%0d: got err=%b lat=%0d req=%0d arr_ok=%b stable=%b ready=%b expected err=%b lat=%0d req=%0d",
                         n, rd, wr, g, rdl, e, lat, rq, ao, so, ra,
                         m_err(rd, wr, rdl), m_lat(rd, wr, g, rdl), m_legal(rd, wr) ? g + 1 : 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; diag_valid = 1'b0; diag_rd = 1'b0; diag_wr = 1'b0; diag_tag_sel = 1'b0;
        diag_addr = '0; diag_way = '0; diag_wrdata = '0; arr_gnt = 1'b0; arr_rvalid = 1'b0;
        arr_rdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_data_read();
        test_tag_write();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_rst_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
